// File: rtl/maxpool_sequencer.sv
// Streaming signed max-pool: reduces each WINDOW-sample group to its maximum
// through a single time-shared compare stage, with valid/ready on both sides.
module maxpool_sequencer #(
    parameter  int WIDTH  = 16,
    parameter  int WINDOW = 4,
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [15:0]      win_count
);

    typedef enum logic [1:0] {
        ST_FIRST,
        ST_ACCUM,
        ST_OUTPUT
    } state_t;

    state_t                  state, state_n;
    logic signed [WIDTH-1:0] acc, acc_n;
    logic signed [WIDTH-1:0] smax_res;
    logic [WIDTH-1:0]        out_data_q, out_data_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [15:0]             win_count_q, win_count_n;
    logic                    in_acc, out_acc, last_elem;

    assign in_ready  = en && !flush && (state != ST_OUTPUT);
    assign out_valid = (state == ST_OUTPUT);
    assign busy      = (state != ST_FIRST);
    assign out_data  = out_data_q;
    assign win_count = win_count_q;

    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;
    assign smax_res  = ($signed(in_data) > acc) ? $signed(in_data) : acc;
    assign last_elem = (cnt == CNT_W'(WINDOW - 1));

    always_comb begin
        state_n     = state;
        acc_n       = acc;
        cnt_n       = cnt;
        out_data_n  = out_data_q;
        win_count_n = win_count_q;
        case (state)
            ST_FIRST: begin
                if (flush) begin
                    cnt_n = '0;
                end else if (in_acc) begin
                    acc_n = $signed(in_data);
                    cnt_n = CNT_W'(1);
                    if (WINDOW == 1) begin
                        state_n    = ST_OUTPUT;
                        out_data_n = in_data;
                    end else begin
                        state_n = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (flush) begin
                    state_n = ST_FIRST;
                    cnt_n   = '0;
                end else if (in_acc) begin
                    acc_n = smax_res;
                    cnt_n = cnt + CNT_W'(1);
                    if (last_elem) begin
                        state_n    = ST_OUTPUT;
                        out_data_n = smax_res;
                    end
                end
            end
            ST_OUTPUT: begin
                if (out_acc) begin
                    state_n     = ST_FIRST;
                    cnt_n       = '0;
                    win_count_n = win_count_q + 16'd1;
                end
            end
            default: state_n = ST_FIRST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FIRST;
            acc         <= '0;
            cnt         <= '0;
            out_data_q  <= '0;
            win_count_q <= '0;
        end else begin
            state       <= state_n;
            acc         <= acc_n;
            cnt         <= cnt_n;
            out_data_q  <= out_data_n;
            win_count_q <= win_count_n;
        end
    end

endmodule

// File: tb/tb_maxpool_sequencer.sv
// Scoreboard bench for maxpool_sequencer: directed windows push expected maxima,
// a negedge monitor pops and compares on every output handshake.
module tb_maxpool_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, en, flush, in_valid, out_ready;
    logic        in_ready, out_valid, busy;
    logic [15:0] in_data, out_data, win_count;
    logic [15:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] wc;

    maxpool_sequencer #(.WIDTH(16), .WINDOW(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .win_count(win_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_output", {31'd0, out_valid}, 32'd0);
            else chk("out_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
        end
    end

    task automatic send(input int d);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = d[15:0];
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) chk("idle_timeout", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic window4(input int a, input int b, input int c, input int d, input logic [15:0] e);
        exp_q.push_back(e);
        send(a); send(b); send(c); send(d);
        wait_idle();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; in_data = '0;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_win_count", {16'd0, win_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: basic window and one-cycle latency
        exp_q.push_back(16'd7);
        send(3); send(-5); send(7);
        chk("t1_pre_valid", {31'd0, out_valid}, 32'd0);
        send(2);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t1_wc_before", {16'd0, win_count}, 32'd0);
        @(posedge clk); #1;
        chk("t1_wc_after", {16'd0, win_count}, 32'd1);
        chk("t1_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("t1_in_ready_back", {31'd0, in_ready}, 32'd1);

        // 2: signed extremes
        window4(-1, -32768, -300, -2, 16'hFFFF);
        window4(-32768, -32768, -32768, -32768, 16'h8000);
        window4(32767, -32768, 0, 1, 16'h7FFF);

        // 3: backpressure
        out_ready = 1'b0;
        wc = win_count;
        exp_q.push_back(16'd4);
        send(1); send(2); send(3); send(4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_hold_data", {16'd0, out_data}, 32'd4);
            chk("t3_hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("t3_hold_wc", {16'd0, win_count}, {16'd0, wc});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        chk("t3_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t3_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("t3_wc", {16'd0, win_count}, {16'd0, wc + 16'd1});

        // 4: gaps and en low while in_valid is asserted
        exp_q.push_back(16'd10);
        send(9);
        repeat (2) @(posedge clk); #1;
        send(-1);
        @(posedge clk); #1;
        en = 1'b0; in_valid = 1'b1; in_data = 16'd55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_en_in_ready", {31'd0, in_ready}, 32'd0);
            chk("t4_en_busy", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end
        en = 1'b1; in_valid = 1'b0;
        send(10); send(4);
        wait_idle();

        // 5: flush with a simultaneous valid sample
        wc = win_count;
        exp_q.push_back(16'd0);
        send(100); send(200);
        flush = 1'b1; in_valid = 1'b1; in_data = 16'd500;
        @(negedge clk);
        chk("t5_flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_flush_busy", {31'd0, busy}, 32'd0);
        send(0); send(0); send(0); send(0);
        wait_idle();
        chk("t5_wc", {16'd0, win_count}, {16'd0, wc + 16'd1});

        // 6: asynchronous reset mid-window and with a pending result
        send(1); send(2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6a_valid", {31'd0, out_valid}, 32'd0);
        chk("t6a_busy", {31'd0, busy}, 32'd0);
        chk("t6a_wc", {16'd0, win_count}, 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(1); send(2); send(3); send(4);
        chk("t6b_pending", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6b_valid", {31'd0, out_valid}, 32'd0);
        chk("t6b_busy", {31'd0, busy}, 32'd0);
        chk("t6b_wc", {16'd0, win_count}, 32'd0);
        chk("t6b_data", {16'd0, out_data}, 32'd0);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        window4(-5, -6, -7, -8, 16'hFFFB);
        chk("t6_wc", {16'd0, win_count}, 32'd1);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
